// File: rtl/mips_instr_encoder.sv
// MIPS ADD/ADDU/SUB/SUBU/ADDI/ADDIU instruction encoder feeding a DEPTH-entry FIFO.
// Define MIPS_ENC_PC_EN to add the out_pc port and per-entry PC tagging (PC_RESET parameter).
module mips_instr_encoder #(
    parameter int DEPTH = 4
`ifdef MIPS_ENC_PC_EN
    ,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
`endif
) (
    input  logic                     CLK,
    input  logic                     Reset_L,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [4:0]               in_rs,
    input  logic [4:0]               in_rt,
    input  logic [4:0]               in_rd,
    input  logic [15:0]              in_imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err,
    output logic [7:0]               err_count
`ifdef MIPS_ENC_PC_EN
    ,
    output logic [31:0]              out_pc
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_FULL
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            err_q, err_d;
    logic [7:0]      err_count_q, err_count_d;
    logic [31:0]     mem_q [DEPTH];

    logic            legal;
    logic [31:0]     enc;
    logic            accept;
    logic            push;
    logic            pop;

    // Opcode/funct encoding; ops 6 and 7 have no encoding and are flagged illegal.
    always_comb begin
        legal = 1'b1;
        enc   = '0;
        case (in_op)
            3'd0:    enc = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h20};
            3'd1:    enc = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h21};
            3'd2:    enc = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h22};
            3'd3:    enc = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h23};
            3'd4:    enc = {6'h08, in_rs, in_rt, in_imm};
            3'd5:    enc = {6'h09, in_rs, in_rt, in_imm};
            default: legal = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign push   = accept && legal;
    assign pop    = out_valid && out_ready;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        err_d       = accept && !legal;
        err_count_d = err_count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // FSM next state tracks the occupancy the FIFO will have after this edge.
    always_comb begin
        state_d = S_PARTIAL;
        if (level_d == '0) begin
            state_d = S_EMPTY;
        end else if (level_d == LW'(DEPTH)) begin
            state_d = S_FULL;
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q     <= S_EMPTY;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc;
        end
    end

    always_comb begin
        out_valid = (state_q != S_EMPTY);
        in_ready  = Reset_L && (state_q != S_FULL);
    end

    assign out_instr = out_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign level     = level_q;
    assign err       = err_q;
    assign err_count = err_count_q;

`ifdef MIPS_ENC_PC_EN
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_mem_q [DEPTH];

    // Illegal ops never reach the FIFO, so they never consume a PC slot.
    always_comb begin
        pc_d = pc_q;
        if (push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem_q[wr_ptr_q] <= pc_q;
        end
    end

    assign out_pc = out_valid ? pc_mem_q[rd_ptr_q] : 32'h0;
`endif

endmodule
